// File: rtl/dmem_ctrl.sv
// Data memory controller: valid/ready request port, byte/half/word accesses with
// sign/zero extension, LATENCY-deep response pipeline and optional zero-fill after reset.
module dmem_ctrl #(
    parameter int DEPTH          = 256,
    parameter int LATENCY        = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        CLEAR,
        IDLE
    } stateT;

    localparam stateT RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

    stateT            state_q, state_d;
    logic [AW-1:0]    clrCnt_q, clrCnt_d;
    logic             clrWe;

    logic [31:0]      mem_q [DEPTH];

    logic             accept;
    logic [AW-1:0]    wordIdx;
    logic [1:0]       lane;
    logic             outOfRange;
    logic             misaligned;
    logic             reqErr;
    logic             storeWe;
    logic [3:0]       wmask;
    logic [31:0]      wdataAligned;
    logic [31:0]      rdWord;
    logic [7:0]       rdByte;
    logic [15:0]      rdHalf;
    logic [31:0]      loadData;
    logic [31:0]      rspData;

    logic [LATENCY-1:0]       vld_q;
    logic [LATENCY-1:0]       err_q;
    logic [LATENCY-1:0][31:0] rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RESET_STATE;
            clrCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            clrCnt_q <= clrCnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clrCnt_d  = clrCnt_q;
        clrWe     = 1'b0;
        req_ready = 1'b0;
        case (state_q)
            CLEAR: begin
                clrWe = 1'b1;
                if (clrCnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end else begin
                    clrCnt_d = clrCnt_q + 1'b1;
                end
            end
            IDLE: begin
                req_ready = 1'b1;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    assign accept     = req_valid && req_ready;
    assign wordIdx    = req_addr[AW+1:2];
    assign lane       = req_addr[1:0];
    assign outOfRange = |req_addr[31:AW+2];
    assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (|req_addr[1:0]));
    assign reqErr     = (req_size == 2'b11) || outOfRange || misaligned;
    assign storeWe    = accept && req_we && !reqErr;

    // Store data is replicated across lanes so the lane mask alone picks what lands.
    always_comb begin
        wmask        = 4'hF;
        wdataAligned = req_wdata;
        case (req_size)
            2'b00: begin
                wmask        = 4'b0001 << lane;
                wdataAligned = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                wmask        = req_addr[1] ? 4'b1100 : 4'b0011;
                wdataAligned = {2{req_wdata[15:0]}};
            end
            default: begin
                wmask        = 4'hF;
                wdataAligned = req_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clrWe) begin
            mem_q[clrCnt_q] <= '0;
        end else if (storeWe) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) begin
                    mem_q[wordIdx][8*b +: 8] <= wdataAligned[8*b +: 8];
                end
            end
        end
    end

    assign rdWord = mem_q[wordIdx];
    assign rdByte = 8'(rdWord >> {lane, 3'b000});
    assign rdHalf = req_addr[1] ? rdWord[31:16] : rdWord[15:0];

    always_comb begin
        loadData = rdWord;
        case (req_size)
            2'b00:   loadData = req_unsigned ? {24'b0, rdByte} : {{24{rdByte[7]}}, rdByte};
            2'b01:   loadData = req_unsigned ? {16'b0, rdHalf} : {{16{rdHalf[15]}}, rdHalf};
            default: loadData = rdWord;
        endcase
    end

    assign rspData = (req_we || reqErr) ? 32'b0 : loadData;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q   <= '0;
            err_q   <= '0;
            rdata_q <= '0;
        end else begin
            vld_q[0]   <= accept;
            err_q[0]   <= accept && reqErr;
            rdata_q[0] <= accept ? rspData : 32'b0;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i]   <= vld_q[i-1];
                err_q[i]   <= err_q[i-1];
                rdata_q[i] <= rdata_q[i-1];
            end
        end
    end

    assign rsp_valid = vld_q[LATENCY-1];
    assign rsp_err   = err_q[LATENCY-1];
    assign rsp_rdata = rdata_q[LATENCY-1];

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (LATENCY 1 and 3) share one request stream and are
// scored against a byte-array memory model with per-instance response queues.
module tb_dmem_ctrl;

    localparam int DEPTH = 64;
    localparam int LAT1  = 1;
    localparam int LAT3  = 3;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } rspT;

    logic        clk;
    logic        resetN;
    logic        reqValid;
    logic        reqWe;
    logic [1:0]  reqSize;
    logic        reqUnsigned;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;

    logic        reqReady1, rspValid1, rspErr1;
    logic [31:0] rspRdata1;
    logic        reqReady3, rspValid3, rspErr3;
    logic [31:0] rspRdata3;

    int          total;
    int          bad;
    int          cyc;
    logic [7:0]  memBytes [4*DEPTH];
    rspT         q1[$];
    rspT         q3[$];

    dmem_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT1), .CLEAR_ON_RESET(1)) u1 (
        .clk(clk), .reset_n(resetN), .req_valid(reqValid), .req_ready(reqReady1),
        .req_we(reqWe), .req_size(reqSize), .req_unsigned(reqUnsigned),
        .req_addr(reqAddr), .req_wdata(reqWdata), .rsp_valid(rspValid1),
        .rsp_rdata(rspRdata1), .rsp_err(rspErr1)
    );

    dmem_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT3), .CLEAR_ON_RESET(1)) u3 (
        .clk(clk), .reset_n(resetN), .req_valid(reqValid), .req_ready(reqReady3),
        .req_we(reqWe), .req_size(reqSize), .req_unsigned(reqUnsigned),
        .req_addr(reqAddr), .req_wdata(reqWdata), .rsp_valid(rspValid3),
        .rsp_rdata(rspRdata3), .rsp_err(rspErr3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Model access: little-endian bytes, size in bytes, extension from the top loaded bit.
    function automatic logic modelErr(input logic [1:0] size, input logic [31:0] addr);
        int n;
        if (size == 2'b11) return 1'b1;
        n = 1 << size;
        if (addr >= 32'(4*DEPTH)) return 1'b1;
        return (addr % n) != 0;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [1:0] size, input logic [31:0] addr, input logic uns);
        int n;
        logic [31:0] v;
        n = 1 << size;
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(memBytes[addr + 32'(i)]) << (8*i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        int waited;
        rspT e;
        waited = 0;
        reqValid = 1'b0;
        while (!reqReady1 && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("readyWait", {31'b0, reqReady1}, 32'd1);
        reqValid    = 1'b1;
        reqWe       = we;
        reqSize     = size;
        reqUnsigned = uns;
        reqAddr     = addr;
        reqWdata    = wdata;
        e.err   = modelErr(size, addr);
        e.rdata = '0;
        if (!e.err) begin
            if (we) begin
                for (int i = 0; i < (1 << size); i++)
                    memBytes[addr + 32'(i)] = 8'(wdata >> (8*i));
            end else begin
                e.rdata = modelLoad(size, addr, uns);
            end
        end
        e.due = cyc + 1 + LAT1 - 1;
        q1.push_back(e);
        e.due = cyc + 1 + LAT3 - 1;
        q3.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        reqValid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        idleCycles(LAT3 + 2);
        checkOutput("drain1", 32'(q1.size()), 32'd0);
        checkOutput("drain3", 32'(q3.size()), 32'd0);
    endtask

    task automatic waitClear();
        int n;
        n = 0;
        while (!reqReady1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("clearLen", 32'(n), 32'(DEPTH));
        checkOutput("ready3", {31'b0, reqReady3}, 32'd1);
    endtask

    always @(negedge clk) begin
        rspT e;
        if (rspValid1) begin
            checkOutput("rspExpected1", {31'b0, q1.size() != 0}, 32'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                checkOutput("rdata1", rspRdata1, e.rdata);
                checkOutput("err1", {31'b0, rspErr1}, {31'b0, e.err});
                checkOutput("cycle1", 32'(cyc), 32'(e.due));
            end
        end
        if (rspValid3) begin
            checkOutput("rspExpected3", {31'b0, q3.size() != 0}, 32'd1);
            if (q3.size() != 0) begin
                e = q3.pop_front();
                checkOutput("rdata3", rspRdata3, e.rdata);
                checkOutput("err3", {31'b0, rspErr3}, {31'b0, e.err});
                checkOutput("cycle3", 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        total       = 0;
        bad         = 0;
        cyc         = 0;
        resetN      = 1'b0;
        reqValid    = 1'b0;
        reqWe       = 1'b0;
        reqSize     = 2'b00;
        reqUnsigned = 1'b0;
        reqAddr     = '0;
        reqWdata    = '0;
        for (int i = 0; i < 4*DEPTH; i++) memBytes[i] = 8'h00;

        #12;
        checkOutput("rstValid1", {31'b0, rspValid1}, 32'd0);
        checkOutput("rstRdata1", rspRdata1, 32'd0);
        checkOutput("rstErr1", {31'b0, rspErr1}, 32'd0);
        checkOutput("rstReady1", {31'b0, reqReady1}, 32'd0);
        checkOutput("rstValid3", {31'b0, rspValid3}, 32'd0);
        checkOutput("rstReady3", {31'b0, reqReady3}, 32'd0);

        @(negedge clk);
        resetN = 1'b1;
        waitClear();

        $display("[TB] clear readback");
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 2'b10, 1'b0, 32'(4*i), 32'h0);
        drain();

        $display("[TB] store/load word");
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h64, 32'h0000_000A);
        idleCycles(1);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h64, 32'h0);
        drain();

        $display("[TB] sub-word");
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_0080);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h26, 32'hFFFF_8001);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h26, 32'h0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h27, 32'h0);
        drain();

        $display("[TB] errors");
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h66, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h64, 32'h0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h23, 32'h0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'(4*DEPTH), 32'h0);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'(4*DEPTH), 32'h55);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 2'b11, 1'b0, 32'h4, 32'hCAFE_F00D);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h4, 32'h0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        drain();

        $display("[TB] streaming");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'b10, 1'b0, 32'(32'h80 + 8*i), 32'hA5A5_0000 + 32'(i));
            applyStimulus(1'b0, 2'b10, 1'b0, 32'(32'h80 + 8*i), 32'h0);
        end
        drain();

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        reqValid = 1'b0;
        resetN   = 1'b0;
        q1.delete();
        q3.delete();
        for (int i = 0; i < 4*DEPTH; i++) memBytes[i] = 8'h00;
        #1;
        checkOutput("midRstValid1", {31'b0, rspValid1}, 32'd0);
        checkOutput("midRstValid3", {31'b0, rspValid3}, 32'd0);
        checkOutput("midRstReady1", {31'b0, reqReady1}, 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        waitClear();
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        drain();

        $display("[TB] random");
        for (int i = 0; i < 300; i++) begin
            logic [31:0] addr;
            addr = (($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 4*DEPTH + 15)));
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          addr, $urandom);
            if ($urandom_range(0, 3) == 0) idleCycles(1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data memory with a valid/ready request port, byte/half/word access sizes, sign/zero extension, configurable read latency and hardware zero-fill after reset. It replaces the plain single-port data memory between the core's load/store stage and storage. It adds three things the plain memory lacks: back-pressure during initialisation, sub-word accesses, and error reporting for misaligned or out-of-range addresses.

## Interface
- DEPTH, 256: number of 32-bit words; power of two, at least 4.
- LATENCY, 1: cycles from request acceptance to response; legal range 1–4.
- CLEAR_ON_RESET, 1: 1 = zero-fill all words after reset; 0 = skip the fill and go straight to IDLE.

- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal and returns an error.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present for one cycle.
- rsp_rdata  out  32  load result after extension; 0 for stores and errors.
- rsp_err  out  1  misaligned access, out-of-range address, or illegal size.

## Operation
- State machine with two states, CLEAR and IDLE.
  - Reset enters CLEAR if CLEAR_ON_RESET = 1, otherwise IDLE.
  - CLEAR: a counter steps 0..DEPTH-1 and writes 0 to one word per cycle. req_ready = 0. After word DEPTH-1 is written, go to IDLE.
  - IDLE: req_ready = 1. A request is accepted on any edge where req_valid && req_ready.
- Address decoding:
  - Word index = req_addr[log2(DEPTH)+1:2]. Byte lane = req_addr[1:0].
  - Out of range when req_addr >= 4*DEPTH.
  - Misaligned when a half access has addr[0] = 1, or a word access has addr[1:0] != 0.
- Stores:
  - Byte store writes lane addr[1:0] with wdata[7:0].
  - Half store writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - Word store writes all four lanes.
  - Lanes not selected are left unchanged.
- Loads:
  - Select the addressed byte or half from the stored word, then extend to 32 bits per req_unsigned.
  - req_unsigned is ignored for word loads.
- Errors: the store is suppressed and the memory is unchanged. The response carries rsp_err = 1 and rsp_rdata = 0.
- Responses: every accepted request, load or store, produces exactly one response, and responses come back in acceptance order.
- Back-to-back requests: one request can be accepted every cycle, with no bubbles.

## Timing
- Reset values: rsp_valid = 0, rsp_rdata = 0, rsp_err = 0. req_ready = 0 if CLEAR_ON_RESET = 1, else 1.
- Reset takes effect asynchronously. Reset release is applied at the next clk edge.
- Clear duration: CLEAR lasts exactly DEPTH cycles, so the first request can be accepted on the (DEPTH+1)-th edge after reset release.
- Response timing: a request accepted at edge N gets its response during the cycle after edge N+LATENCY-1. With LATENCY = 1, rsp_valid is high in the cycle right after acceptance. The response pipeline is LATENCY stages deep.
- Write-to-read ordering:
  - A store accepted at edge N updates the memory at edge N.
  - A load accepted at edge N+1 or later returns the new data.
  - There is no same-cycle hazard because only one request is accepted per cycle.
- Reset in the middle of operation:
  - All in-flight responses are dropped and rsp_valid goes to 0 immediately.
  - The controller re-enters CLEAR (memory is re-zeroed) or IDLE, according to CLEAR_ON_RESET.
- While req_ready = 0, req_valid is ignored and no response is produced for it.
- Wrap-around: the clear counter never wraps; it stops at DEPTH-1. Addresses never wrap; any req_addr >= 4*DEPTH is an error.

## Test plan
- Clear: DEPTH = 16, CLEAR_ON_RESET = 1, release reset → req_ready stays 0 for exactly 16 cycles; word loads of 0x00, 0x04, …, 0x3C all return 0.
- Store/load: word store 0x0000000A to 0x64, then word load from 0x64 → 0x0000000A with rsp_err = 0 and LATENCY-cycle response spacing. Repeat for LATENCY = 1 and LATENCY = 3.
- Sub-word access: word store 0x11223344 to 0x20, then byte store 0x80 to 0x21.
  - Byte load from 0x21, signed → 0xFFFFFF80.
  - Byte load from 0x21, unsigned → 0x00000080.
  - Half load from 0x22 → 0x00001122.
  - Word load from 0x20 → 0x11228044.
- Errors:
  - Word store 0xDEADBEEF to 0x66 → rsp_err = 1, and the memory word is unchanged.
  - Half load from 0x23 → rsp_err = 1.
  - Load from 4*DEPTH → rsp_err = 1, rsp_rdata = 0.
  - Access with size = 11 → rsp_err = 1.
- Streaming: 8 back-to-back requests with req_valid held high (alternating stores and loads to consecutive words) → 8 responses on consecutive cycles, in order, with correct data.
- Reset mid-operation: assert reset_n = 0 with 2 loads in flight (LATENCY = 3) → no responses emerge, rsp_valid = 0 immediately, req_ready = 0 during the re-clear, and the previously stored word reads back as 0.
